cbc_chain_ctrl: RTL and testbench

- Upstream mode controller for cripto_module (64-bit block, 256-bit key, start/busy/ready core).
- Accepts a stream of 64-bit blocks over valid/ready and applies CBC chaining.
- Sequences the core with one start pulse per block and returns results on an output valid/ready stream.
- Turns the single-block core into a multi-block CBC encrypt/decrypt engine.

---
 rtl/cbc_chain_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cbc_chain_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbc_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cbc_chain_ctrl
// Description : CBC encrypt/decrypt mode controller in front of a single-block
//               start/busy/ready cipher core. Optional ECB bypass is enabled
//               with the CBC_ECB_BYPASS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module cbc_chain_ctrl #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int TO_W        = 11
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cfg_load,
    input  logic         cfg_dec,
    input  logic [255:0] cfg_key,
    input  logic [63:0]  cfg_iv,
`ifdef CBC_ECB_BYPASS_EN
    input  logic         cfg_ecb,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    output logic         core_start,
    output logic         core_enc_dec,
    output logic [63:0]  core_data,
    output logic [255:0] core_key,
    input  logic         core_busy,
    input  logic         core_ready,
    input  logic [63:0]  core_data_o,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         out_last,
    output logic         err_timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [TO_W-1:0] C_TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_cfg_ok;
    logic            r_enc;
    logic [255:0]    r_key;
    logic [63:0]     r_iv;
    logic [63:0]     r_chain;
    logic [63:0]     r_blk;
    logic            r_last;
    logic [63:0]     r_core_data;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_out_valid;
    logic [63:0]     r_out_data;
    logic            r_out_last;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_done;
    logic            w_timeout;
    logic            w_out_hs;
    logic            w_ecb;
    logic            w_unused;

    // The core's busy flag is informational only; sequencing relies on core_ready.
    assign w_unused = core_busy;

`ifdef CBC_ECB_BYPASS_EN
    logic r_ecb;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ecb <= 1'b0;
        end else if (r_state == S_IDLE && cfg_load) begin
            r_ecb <= cfg_ecb;
        end
    end
    assign w_ecb = r_ecb;
`else
    assign w_ecb = 1'b0;
`endif

    assign w_in_ready = (r_state == S_IDLE) && r_cfg_ok && !cfg_load;
    assign w_accept   = w_in_ready && in_valid;
    assign w_done     = (r_state == S_WAIT) && core_ready;
    assign w_timeout  = (r_state == S_WAIT) && !core_ready && (r_to_cnt == C_TO_LAST);
    assign w_out_hs   = (r_state == S_OUT) && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (core_ready)                  w_state_nxt = S_OUT;
                else if (r_to_cnt == C_TO_LAST)  w_state_nxt = S_IDLE;
            end
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfg_ok    <= 1'b0;
            r_enc       <= 1'b0;
            r_key       <= '0;
            r_iv        <= '0;
            r_chain     <= '0;
            r_blk       <= '0;
            r_last      <= 1'b0;
            r_core_data <= '0;
            r_to_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && cfg_load) begin
                r_key    <= cfg_key;
                r_iv     <= cfg_iv;
                r_enc    <= ~cfg_dec;
                r_chain  <= cfg_iv;
                r_cfg_ok <= 1'b1;
            end

            // Encrypt whitens the plaintext with the chain; decrypt sends ciphertext as-is.
            if (w_accept) begin
                r_blk       <= in_data;
                r_last      <= in_last;
                r_core_data <= (r_enc && !w_ecb) ? (in_data ^ r_chain) : in_data;
            end

            if (r_state == S_ISSUE) begin
                r_to_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (w_done) begin
                r_out_data  <= (r_enc || w_ecb) ? core_data_o : (core_data_o ^ r_chain);
                r_chain     <= r_enc ? core_data_o : r_blk;
                r_out_last  <= r_last;
                r_out_valid <= 1'b1;
            end

            // A stalled core leaves the key/chain state suspect, so force a reconfigure.
            if (w_timeout) begin
                r_cfg_ok <= 1'b0;
            end

            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                if (r_out_last) begin
                    r_chain <= r_iv;
                end
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign core_start   = (r_state == S_ISSUE);
    assign core_enc_dec = r_enc;
    assign core_data    = r_core_data;
    assign core_key     = r_key;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign err_timeout  = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_cbc_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbc_chain_ctrl
// Description : Scoreboard bench for cbc_chain_ctrl with an XOR-cipher core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbc_chain_ctrl;

    localparam int TIMEOUT_CYC = 1024;
    localparam int TO_W        = 11;
    localparam int LAT         = 3;
    localparam logic [63:0]  K_E  = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0]  K_D  = 64'hF0E1D2C3B4A59687;
    localparam logic [255:0] KEY1 = 256'hDEADBEEF0123456789ABCDEFDEADBEEFDEADBEEF0123456789ABCDEFDEADBEEF;
    localparam logic [255:0] KEY2 = 256'h00112233445566778899AABBCCDDEEFF0123456789ABCDEFFEDCBA9876543210;
    localparam logic [255:0] KEY3 = 256'hCAFEBABECAFEBABECAFEBABECAFEBABECAFEBABECAFEBABECAFEBABECAFEBABE;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cfg_load = 1'b0;
    logic         cfg_dec = 1'b0;
    logic [255:0] cfg_key = '0;
    logic [63:0]  cfg_iv = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic         core_start;
    logic         core_enc_dec;
    logic [63:0]  core_data;
    logic [255:0] core_key;
    logic         core_busy = 1'b0;
    logic         core_ready;
    logic [63:0]  core_data_o = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [63:0]  out_data;
    logic         out_last;
    logic         err_timeout;

    logic         m_ready = 1'b0;
    logic         inj_ready = 1'b0;
    logic         model_en = 1'b1;
    int           m_cnt = 0;
    logic [63:0]  m_in = '0;
    logic         m_enc = 1'b0;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           start_cyc = 0;
    int           err_delay = 0;
    int           n_out = 0;
    int           n_err = 0;
    logic [255:0] exp_key = '0;
    logic [64:0]  core_q[$];
    logic [64:0]  out_q[$];

    assign core_ready = m_ready | inj_ready;

    cbc_chain_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) dut (
        .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_dec(cfg_dec),
        .cfg_key(cfg_key), .cfg_iv(cfg_iv),
`ifdef CBC_ECB_BYPASS_EN
        .cfg_ecb(1'b0),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .core_start(core_start), .core_enc_dec(core_enc_dec), .core_data(core_data),
        .core_key(core_key), .core_busy(core_busy), .core_ready(core_ready),
        .core_data_o(core_data_o), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Core model: fixed latency, XOR cipher with distinct enc/dec keys.
    always @(posedge clock) begin
        m_ready <= 1'b0;
        if (reset) begin
            m_cnt     <= 0;
            core_busy <= 1'b0;
        end else if (core_start && model_en) begin
            m_cnt     <= LAT;
            m_in      <= core_data;
            m_enc     <= core_enc_dec;
            core_busy <= 1'b1;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_ready     <= 1'b1;
                core_data_o <= m_enc ? (m_in ^ K_E) : (m_in ^ K_D);
                core_busy   <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected core requests and output beats as the DUT presents them.
    always @(negedge clock) begin
        if (!reset) begin
            if (core_start) begin
                start_cyc = cyc;
                if (core_q.size() == 0) begin
                    chk("core_start_unexpected", core_start, 1'b0);
                end else begin
                    logic [64:0] e;
                    e = core_q.pop_front();
                    chk("core_data", core_data, e[63:0]);
                    chk("core_enc_dec", core_enc_dec, e[64]);
                    chk("core_key", core_key, exp_key);
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (out_q.size() == 0) begin
                    chk("out_unexpected", out_valid, 1'b0);
                end else begin
                    logic [64:0] e;
                    e = out_q.pop_front();
                    chk("out_data", out_data, e[63:0]);
                    chk("out_last", out_last, e[64]);
                end
            end
            if (err_timeout) begin
                n_err++;
                err_delay = cyc - start_cyc;
            end
        end
    end

    task automatic cfg(input logic [255:0] k, input logic [63:0] iv, input logic dec);
        cfg_load = 1'b1;
        cfg_key  = k;
        cfg_iv   = iv;
        cfg_dec  = dec;
        @(posedge clock); #1;
        cfg_load = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic l);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (k < 200) begin
            @(negedge clock);
            if (in_ready) break;
            k++;
        end
        chk("send_accept", in_ready, 1'b1);
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        int k = 0;
        while (n_out < n && k < 100) begin
            @(negedge clock);
            k++;
        end
        chk("out_count", n_out >= n, 1'b1);
        @(posedge clock); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_core_start"}, core_start, 0);
        chk({tag, "_core_enc_dec"}, core_enc_dec, 0);
        chk({tag, "_core_data"}, core_data, 0);
        chk({tag, "_core_key"}, core_key, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [63:0] held;

        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_zero("reset");
        @(posedge clock); #1;

        // CBC encrypt, iv = 0
        exp_key = KEY1;
        cfg(KEY1, 64'h0, 1'b0);

        // Stray core_ready while idle must be ignored
        inj_ready = 1'b1;
        @(posedge clock); #1;
        inj_ready = 1'b0;
        @(negedge clock);
        chk("stray_ready_out_valid", out_valid, 1'b0);
        chk("stray_ready_in_ready", in_ready, 1'b1);
        @(posedge clock); #1;

        core_q.push_back({1'b1, 64'hA5A5A5A501234567});
        out_q.push_back({1'b0, 64'hAABB88994A792C1F});
        send(64'hA5A5A5A501234567, 1'b0);
        wait_outs(1);

        core_q.push_back({1'b1, 64'hAB98CDFEC3D2E1F0});
        out_q.push_back({1'b1, 64'hA486E0C288888888});
        send(64'h0123456789ABCDEF, 1'b1);
        wait_outs(2);

        // New message after in_last: chain restarts from iv
        core_q.push_back({1'b1, 64'h1122334455667788});
        out_q.push_back({1'b1, 64'h1E3C1E781E3C1EF0});
        send(64'h1122334455667788, 1'b1);
        wait_outs(3);

        // cfg_load coinciding with in_valid: no block accepted
        cfg_load = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        @(negedge clock);
        chk("cfg_vs_valid_in_ready", in_ready, 1'b0);
        @(posedge clock); #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // CBC decrypt with backpressure on the first output
        exp_key = KEY2;
        cfg(KEY2, 64'h1111111111111111, 1'b1);
        out_ready = 1'b0;
        core_q.push_back({1'b0, 64'h0123456789ABCDEF});
        out_q.push_back({1'b0, 64'hE0D386B52C1F4A79});
        send(64'h0123456789ABCDEF, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid) break;
        end
        chk("bp_out_valid_seen", out_valid, 1'b1);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (!out_valid || out_data !== held || in_ready) bad++;
        end
        chk("bp_stable_cycles_bad", bad, 0);
        chk("bp_held_data", held, 64'hE0D386B52C1F4A79);
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_outs(4);

        core_q.push_back({1'b0, 64'hFEDCBA9876543210});
        out_q.push_back({1'b1, 64'h0F1E2D3C4B5A6978});
        send(64'hFEDCBA9876543210, 1'b1);
        @(posedge clock); #1;
        // Reconfiguration attempt while waiting on the core is ignored
        cfg(KEY3, 64'h0, 1'b0);
        wait_outs(5);
        @(negedge clock);
        chk("cfg_in_wait_key", core_key, KEY2);
        chk("cfg_in_wait_mode", core_enc_dec, 1'b0);
        @(posedge clock); #1;

        core_q.push_back({1'b0, 64'h0123456789ABCDEF});
        out_q.push_back({1'b1, 64'hE0D386B52C1F4A79});
        send(64'h0123456789ABCDEF, 1'b1);
        wait_outs(6);

        // Core never answers
        model_en = 1'b0;
        core_q.push_back({1'b0, 64'h5555555555555555});
        send(64'h5555555555555555, 1'b1);
        for (int i = 0; i < 1200; i++) begin
            if (n_err != 0) break;
            @(negedge clock);
        end
        chk("timeout_seen", n_err, 1);
        chk("timeout_delay", err_delay, TIMEOUT_CYC);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (in_ready || out_valid) bad++;
        end
        chk("timeout_idle_bad", bad, 0);
        chk("timeout_pulse_count", n_err, 1);
        @(posedge clock); #1;
        cfg(KEY2, 64'h1111111111111111, 1'b1);
        @(negedge clock);
        chk("reconfig_in_ready", in_ready, 1'b1);
        @(posedge clock); #1;

        // Reset while waiting on the core
        core_q.push_back({1'b0, 64'h0123456789ABCDEF});
        send(64'h0123456789ABCDEF, 1'b0);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_zero("midreset");
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (in_ready) bad++;
        end
        chk("midreset_in_ready_bad", bad, 0);
        @(posedge clock); #1;

        // Recovery after reconfiguration
        model_en = 1'b1;
        exp_key  = KEY1;
        cfg(KEY1, 64'h0, 1'b0);
        core_q.push_back({1'b1, 64'hA5A5A5A501234567});
        out_q.push_back({1'b1, 64'hAABB88994A792C1F});
        send(64'hA5A5A5A501234567, 1'b1);
        wait_outs(7);

        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("core_q_left", core_q.size(), 0);
        chk("out_q_left", out_q.size(), 0);
        chk("err_total", n_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
